// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: constants and bundle types
// shared by the RV64 pipeline stages.
package rv_pipe_pkg;

  localparam int XLEN = 64;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } if_id_t;

endpackage

// File: rtl/fetch_resp_fifo.sv
// fetch_resp_fifo: small synchronous FIFO that
// buffers instruction-memory responses.
module fetch_resp_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Pointer and occupancy update; flush wins.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is unreset; cnt_q says what is live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the fetch PC, issues in-order
// imem requests and loads the IF/ID register.
import rv_pipe_pkg::*;

module fetch_stage #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] deliver_pc_q, deliver_pc_d;
  logic [CW-1:0]   in_flight_q, in_flight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]     if_id_instr_q, if_id_instr_d;

  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            drop_rsp;
  logic            take_rsp;
  logic            if_id_load;
  logic            bypass;
  logic [XLEN-1:0] redirect_tgt;

  logic            fifo_push;
  logic            fifo_pop;
  logic [31:0]     fifo_rdata;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;

  // Outstanding plus buffered never exceeds the
  // FIFO size, so every response has a slot.
  assign credit_used = {1'b0, in_flight_q}
                     + {1'b0, fifo_count};

  assign imem_req_valid = !redirect_valid
    && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire = imem_req_valid
                 && imem_req_ready;

  assign drop_rsp = imem_rsp_valid
    && (redirect_valid || drop_cnt_q != '0);
  assign take_rsp = imem_rsp_valid && !drop_rsp;

  assign if_id_load = !if_id_valid_q || !stall;
  assign bypass     = take_rsp && fifo_empty
                   && if_id_load;
  assign fifo_push  = take_rsp && !bypass;
  assign fifo_pop   = if_id_load && !fifo_empty
                   && !redirect_valid;

  assign redirect_tgt = redirect_pc
                      & ~XLEN'(3);

  fetch_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (imem_rsp_data),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Next-state: redirect first, then IF/ID load.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    deliver_pc_d  = deliver_pc_q;
    drop_cnt_d    = drop_cnt_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    in_flight_d   = in_flight_q
                  + CW'(req_fire)
                  - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      fetch_pc_d    = redirect_tgt;
      deliver_pc_d  = redirect_tgt;
      drop_cnt_d    = in_flight_q
                    - CW'(imem_rsp_valid);
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP;
    end else begin
      if (req_fire)
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rsp_valid && drop_cnt_q != '0)
        drop_cnt_d = drop_cnt_q - CW'(1);
      if (bypass || fifo_pop) begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = deliver_pc_q;
        if_id_instr_d = bypass ? imem_rsp_data
                               : fifo_rdata;
        deliver_pc_d  = deliver_pc_q + XLEN'(4);
      end else if (if_id_load) begin
        if_id_valid_d = 1'b0;
        if_id_instr_d = NOP;
      end
    end
  end

  // Stage state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      deliver_pc_q  <= RESET_PC;
      in_flight_q   <= '0;
      drop_cnt_q    <= '0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      deliver_pc_q  <= deliver_pc_d;
      in_flight_q   <= in_flight_d;
      drop_cnt_q    <= drop_cnt_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

  // A kept response must always find a free slot.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(fifo_push && fifo_full));
  end

  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;

endmodule
